gpc_axi_register: RTL and testbench
===================================

GPC_AXI_REGISTER -- requirements
Module: gpc_axi_register

Interface
REQ-001 SHALL have parameter AXIL_ADDR_WIDTH, default 64, AXI-Lite address width.
REQ-002 SHALL have parameter AXIL_DATA_WIDTH, default 64, AXI-Lite data width; only 64 is supported.
REQ-003 SHALL have parameter AXIL_STRB_WIDTH, default AXIL_DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameter AXIS_DATA_WIDTH, default 512, stream data width; only 512 is supported, giving 8 data words of 64 bits.
REQ-005 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, tkeep width.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock (all logic on rising edge); rst  in  1  reset.
REQ-007 SHALL have the AXI-Lite read ports: s_axil_araddr in AW; s_axil_arprot in 3 (ignored); s_axil_arvalid in 1; s_axil_arready out 1; s_axil_rdata out DW; s_axil_rvalid out 1; s_axil_rready in 1; s_axil_rresp out 2.
REQ-008 SHALL have the AXI-Lite write ports: s_axil_awaddr in AW; s_axil_awprot in 3 (ignored); s_axil_awvalid in 1; s_axil_awready out 1; s_axil_wdata in DW; s_axil_wstrb in SW; s_axil_wvalid in 1; s_axil_wready out 1; s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-009 SHALL have the RX stream slave ports (from CMAC): s_axis_tdata in 512; s_axis_tkeep in 64; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1.
REQ-010 SHALL have the TX stream master ports (to CMAC): m_axis_tdata out 512; m_axis_tkeep out 64; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tlast out 1.

Function
REQ-011 SHALL decode the register map on byte address bits [7:3]; all registers are 64 bits wide:
- 0x00 CTRL: bit0 rx_en (RW); bit1 tx_start (write-1, self-clearing); bit2 cnt_clr (write-1, self-clearing).
- 0x08 STATUS: bit0 tx_busy (RO); bit1 rx_valid (write-1-to-clear).
- 0x10 TX_KEEP (RW); 0x18 TX_LAST bit0 (RW).
- 0x20 RX_KEEP (RO); 0x28 RX_LAST bit0 (RO).
- 0x30 RX_CNT (RO); 0x38 TX_CNT (RO).
- 0x40-0x78 TX_DATA[0..7] (RW); 0x80-0xB8 RX_DATA[0..7] (RO).
- Word i maps to stream bits [64i+63:64i].
REQ-012 SHALL accept a write only when awvalid and wvalid are both high and bvalid is low; awready and wready pulse together for 1 cycle; bvalid rises the next cycle and holds until bready.
REQ-013 SHALL apply wstrb per byte on RW registers; writes to RO fields SHALL be ignored.
REQ-014 SHALL accept a read when arvalid is high and rvalid is low (arready 1-cycle pulse); rdata and rvalid are registered with 1-cycle latency and held until rready.
REQ-015 SHALL return resp 2'b00 for addresses 0x00-0xB8 and 2'b10 (SLVERR) with rdata 0 for any other address; SLVERR writes have no effect.
REQ-016 SHALL drive s_axis_tready = rx_en & ~rx_valid; on a handshake it captures tdata, tkeep and tlast into RX_DATA, RX_KEEP and RX_LAST, sets rx_valid, and increments RX_CNT.
REQ-017 SHALL start TX on a tx_start write while tx_busy=0: m_axis_tvalid=1 from the next cycle, driving TX_DATA, TX_KEEP and TX_LAST; after tready&tvalid it clears tvalid, increments TX_CNT, and clears tx_busy. tx_start while busy SHALL be ignored.
REQ-018 SHALL ignore writes to TX_DATA, TX_KEEP and TX_LAST while tx_busy=1, so the m_axis outputs stay stable.
REQ-019 SHALL wrap the counters (64-bit) to 0; cnt_clr zeroes both counters, and cnt_clr takes precedence over a simultaneous increment.
REQ-020 SHALL give priority to a new capture over a clear when an rx_valid W1C and a new capture fall in the same cycle; this cannot occur while tready=0.

Reset
REQ-021 SHALL zero all registers and counters on rst.
REQ-022 SHALL drive every output to 0 during and after rst, including any handshake in progress when rst is asserted mid-operation.

Configuration
REQ-023 SHALL compile RX_CNT and TX_CNT only when GPC_AXI_REGISTER_COUNTERS_EN is defined; without it both read 0, cnt_clr has no effect, and no counter flops are built.

Structure
REQ-024 SHALL place the register offsets, CTRL/STATUS bit indices and response codes in package gpc_axi_register_pkg.
REQ-025 SHALL implement the AXI-Lite handshake logic as sub-module gpc_axi_register_axil_if, which exposes a 1-cycle wr_en/rd_en, address, data and strobe.

Verification
REQ-026 SHALL cover: write 0xDEADBEEF_00000001 to TX_DATA[0], then read it back -> rdata equals the written value, rresp 0.
REQ-027 SHALL cover: set TX_KEEP all-ones and TX_LAST=1, write CTRL 0x2, hold tready low for 3 cycles -> tvalid and data stay stable; raise tready -> 1 beat transferred, TX_CNT=1, tx_busy=0.
REQ-028 SHALL cover: write CTRL 0x1, then send a beat with tkeep 0xFF and tlast=1 -> RX_KEEP=0xFF, RX_LAST=1, STATUS=0x2, tready=0; write STATUS 0x2 -> tready returns to 1.
REQ-029 SHALL cover: read address 0x100 -> rresp 2'b10, rdata 0; write wstrb 0x01 to TX_KEEP -> only byte 0 updates.
REQ-030 SHALL cover: assert rst while tvalid=1 -> tvalid=0 and all registers read 0 afterwards.

Source files
------------

// File: rtl/gpc_axi_register_pkg.sv
// Shared constants for the GPC AXI-Lite register block: register offsets,
// CTRL/STATUS bit positions, AXI response codes and the byte-strobe merge helper.
package gpc_axi_register_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_TX_KEEP = 8'h10;
  localparam logic [7:0] OFF_TX_LAST = 8'h18;
  localparam logic [7:0] OFF_RX_KEEP = 8'h20;
  localparam logic [7:0] OFF_RX_LAST = 8'h28;
  localparam logic [7:0] OFF_RX_CNT  = 8'h30;
  localparam logic [7:0] OFF_TX_CNT  = 8'h38;
  localparam logic [7:0] OFF_TX_DATA = 8'h40;
  localparam logic [7:0] OFF_RX_DATA = 8'h80;
  localparam logic [7:0] OFF_LAST    = 8'hB8;

  // Word indices: the map decodes on byte address bits [7:3].
  localparam logic [4:0] IDX_CTRL    = OFF_CTRL[7:3];
  localparam logic [4:0] IDX_STATUS  = OFF_STATUS[7:3];
  localparam logic [4:0] IDX_TX_KEEP = OFF_TX_KEEP[7:3];
  localparam logic [4:0] IDX_TX_LAST = OFF_TX_LAST[7:3];
  localparam logic [4:0] IDX_RX_KEEP = OFF_RX_KEEP[7:3];
  localparam logic [4:0] IDX_RX_LAST = OFF_RX_LAST[7:3];
  localparam logic [4:0] IDX_RX_CNT  = OFF_RX_CNT[7:3];
  localparam logic [4:0] IDX_TX_CNT  = OFF_TX_CNT[7:3];
  localparam logic [4:0] IDX_TX_DATA = OFF_TX_DATA[7:3];
  localparam logic [4:0] IDX_RX_DATA = OFF_RX_DATA[7:3];
  localparam logic [4:0] IDX_LAST    = OFF_LAST[7:3];

  localparam int CTRL_RX_EN      = 0;
  localparam int CTRL_TX_START   = 1;
  localparam int CTRL_CNT_CLR    = 2;
  localparam int STATUS_TX_BUSY  = 0;
  localparam int STATUS_RX_VALID = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [63:0] apply_strb(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/gpc_axi_register_axil_if.sv
// AXI-Lite slave handshake: turns AW/W/B and AR/R channels into single-cycle
// wr_en/rd_en strobes with address, data and strobe; read data is registered.
// Handshake rule: a channel beat transfers on a rising edge where valid and
// ready are both high; a write needs AW and W together with no B pending, a
// read needs no R pending, and B/R stay valid until the master's ready.
module gpc_axi_register_axil_if #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int SW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] s_axil_awaddr_i,
  input  logic          s_axil_awvalid_i,
  output logic          s_axil_awready_o,
  input  logic [DW-1:0] s_axil_wdata_i,
  input  logic [SW-1:0] s_axil_wstrb_i,
  input  logic          s_axil_wvalid_i,
  output logic          s_axil_wready_o,
  output logic [1:0]    s_axil_bresp_o,
  output logic          s_axil_bvalid_o,
  input  logic          s_axil_bready_i,
  input  logic [AW-1:0] s_axil_araddr_i,
  input  logic          s_axil_arvalid_i,
  output logic          s_axil_arready_o,
  output logic [DW-1:0] s_axil_rdata_o,
  output logic [1:0]    s_axil_rresp_o,
  output logic          s_axil_rvalid_o,
  input  logic          s_axil_rready_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic [SW-1:0] wr_strb_o,
  input  logic [1:0]    wr_resp_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [DW-1:0] rd_data_i,
  input  logic [1:0]    rd_resp_i
);

  logic          bvalid_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [DW-1:0] rdata_q;

  assign wr_en_o   = s_axil_awvalid_i & s_axil_wvalid_i & ~bvalid_q & ~rst;
  assign rd_en_o   = s_axil_arvalid_i & ~rvalid_q & ~rst;
  assign wr_addr_o = s_axil_awaddr_i;
  assign wr_data_o = s_axil_wdata_i;
  assign wr_strb_o = s_axil_wstrb_i;
  assign rd_addr_o = s_axil_araddr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
    end else begin
      if (wr_en_o) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp_i;
      end else if (s_axil_bready_i) begin
        bvalid_q <= 1'b0;
      end
      if (rd_en_o) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_i;
        rresp_q  <= rd_resp_i;
      end else if (s_axil_rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Outputs are forced low while reset is held, not only after the edge.
  assign s_axil_awready_o = wr_en_o;
  assign s_axil_wready_o  = wr_en_o;
  assign s_axil_arready_o = rd_en_o;
  assign s_axil_bvalid_o  = bvalid_q & ~rst;
  assign s_axil_bresp_o   = bresp_q & {2{~rst}};
  assign s_axil_rvalid_o  = rvalid_q & ~rst;
  assign s_axil_rresp_o   = rresp_q & {2{~rst}};
  assign s_axil_rdata_o   = rdata_q & {DW{~rst}};

endmodule

// File: rtl/gpc_axi_register.sv
// AXI-Lite register window onto one 512-bit CMAC stream beat in each direction.
// Define GPC_AXI_REGISTER_COUNTERS_EN to build the RX_CNT/TX_CNT beat counters.
module gpc_axi_register
  import gpc_axi_register_pkg::*;
#(
  parameter int AXIL_ADDR_WIDTH = 64,
  parameter int AXIL_DATA_WIDTH = 64,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic [1:0]                 s_axil_rresp,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  logic                       wr_en, rd_en;
  logic [AXIL_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [AXIL_DATA_WIDTH-1:0] wr_data, rd_data;
  logic [AXIL_STRB_WIDTH-1:0] wr_strb;
  logic [1:0]                 wr_resp, rd_resp;

  logic        rx_en_q, tx_busy_q, rx_valid_q, tx_last_q, rx_last_q;
  logic [63:0] tx_keep_q, rx_keep_q, rx_cnt, tx_cnt;
  logic [7:0][63:0] tx_data_q, rx_data_q;

  logic [4:0]  wr_idx, rd_idx;
  logic        wr_hit, ctrl_wr, tx_start, rx_ready, rx_fire, tx_fire;
  logic [63:0] rd_word;
  logic        unused_prot;

  assign unused_prot = ^{s_axil_arprot, s_axil_awprot};

  gpc_axi_register_axil_if #(
    .AW(AXIL_ADDR_WIDTH), .DW(AXIL_DATA_WIDTH), .SW(AXIL_STRB_WIDTH)
  ) u_axil_if (
    .clk, .rst,
    .s_axil_awaddr_i(s_axil_awaddr),   .s_axil_awvalid_i(s_axil_awvalid),
    .s_axil_awready_o(s_axil_awready), .s_axil_wdata_i(s_axil_wdata),
    .s_axil_wstrb_i(s_axil_wstrb),     .s_axil_wvalid_i(s_axil_wvalid),
    .s_axil_wready_o(s_axil_wready),   .s_axil_bresp_o(s_axil_bresp),
    .s_axil_bvalid_o(s_axil_bvalid),   .s_axil_bready_i(s_axil_bready),
    .s_axil_araddr_i(s_axil_araddr),   .s_axil_arvalid_i(s_axil_arvalid),
    .s_axil_arready_o(s_axil_arready), .s_axil_rdata_o(s_axil_rdata),
    .s_axil_rresp_o(s_axil_rresp),     .s_axil_rvalid_o(s_axil_rvalid),
    .s_axil_rready_i(s_axil_rready),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_strb_o(wr_strb),
    .wr_resp_i(wr_resp), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .rd_resp_i(rd_resp)
  );

  // Upper address bits must be zero so e.g. 0x100 does not alias onto CTRL.
  function automatic logic addr_ok(input logic [AXIL_ADDR_WIDTH-1:0] a);
    return (a[AXIL_ADDR_WIDTH-1:8] == '0) && (a[7:3] <= IDX_LAST);
  endfunction

  assign wr_idx   = wr_addr[7:3];
  assign rd_idx   = rd_addr[7:3];
  assign wr_hit   = wr_en & addr_ok(wr_addr);
  assign ctrl_wr  = wr_hit & (wr_idx == IDX_CTRL) & wr_strb[0];
  assign tx_start = ctrl_wr & wr_data[CTRL_TX_START] & ~tx_busy_q;
  assign rx_ready = rx_en_q & ~rx_valid_q;
  assign rx_fire  = rx_ready & s_axis_tvalid;
  assign tx_fire  = tx_busy_q & m_axis_tready;
  assign wr_resp  = addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_en_q    <= 1'b0;
      tx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      rx_last_q  <= 1'b0;
      tx_keep_q  <= '0;
      rx_keep_q  <= '0;
      tx_data_q  <= '0;
      rx_data_q  <= '0;
    end else begin
      if (ctrl_wr) rx_en_q <= wr_data[CTRL_RX_EN];
      if (tx_start)     tx_busy_q <= 1'b1;
      else if (tx_fire) tx_busy_q <= 1'b0;
      // A fresh capture wins over a same-cycle write-1-to-clear.
      if (rx_fire) rx_valid_q <= 1'b1;
      else if (wr_hit && wr_idx == IDX_STATUS && wr_strb[0] && wr_data[STATUS_RX_VALID])
        rx_valid_q <= 1'b0;
      // The outgoing beat is frozen while it is being presented.
      if (wr_hit && !tx_busy_q) begin
        if (wr_idx == IDX_TX_KEEP) tx_keep_q <= apply_strb(tx_keep_q, wr_data, wr_strb);
        if (wr_idx == IDX_TX_LAST && wr_strb[0]) tx_last_q <= wr_data[0];
        if (wr_idx[4:3] == IDX_TX_DATA[4:3])
          tx_data_q[wr_idx[2:0]] <= apply_strb(tx_data_q[wr_idx[2:0]], wr_data, wr_strb);
      end
      if (rx_fire) begin
        rx_data_q <= s_axis_tdata;
        rx_keep_q <= s_axis_tkeep;
        rx_last_q <= s_axis_tlast;
      end
    end
  end

`ifdef GPC_AXI_REGISTER_COUNTERS_EN
  logic        cnt_clr;
  logic [63:0] rx_cnt_q, tx_cnt_q;
  assign cnt_clr = ctrl_wr & wr_data[CTRL_CNT_CLR];
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (rx_fire) rx_cnt_q <= rx_cnt_q + 64'd1;
      if (tx_fire) tx_cnt_q <= tx_cnt_q + 64'd1;
    end
  end
  assign rx_cnt = rx_cnt_q;
  assign tx_cnt = tx_cnt_q;
`else
  assign rx_cnt = '0;
  assign tx_cnt = '0;
`endif

  always_comb begin
    rd_word = '0;
    case (rd_idx)
      IDX_CTRL:    rd_word[CTRL_RX_EN] = rx_en_q;
      IDX_STATUS: begin
        rd_word[STATUS_TX_BUSY]  = tx_busy_q;
        rd_word[STATUS_RX_VALID] = rx_valid_q;
      end
      IDX_TX_KEEP: rd_word = tx_keep_q;
      IDX_TX_LAST: rd_word[0] = tx_last_q;
      IDX_RX_KEEP: rd_word = rx_keep_q;
      IDX_RX_LAST: rd_word[0] = rx_last_q;
      IDX_RX_CNT:  rd_word = rx_cnt;
      IDX_TX_CNT:  rd_word = tx_cnt;
      default: begin
        if (rd_idx[4:3] == IDX_TX_DATA[4:3])      rd_word = tx_data_q[rd_idx[2:0]];
        else if (rd_idx[4:3] == IDX_RX_DATA[4:3]) rd_word = rx_data_q[rd_idx[2:0]];
      end
    endcase
    if (!addr_ok(rd_addr)) rd_word = '0;
  end

  assign rd_data = rd_word;
  assign rd_resp = addr_ok(rd_addr) ? RESP_OKAY : RESP_SLVERR;

  assign s_axis_tready = rx_ready & ~rst;
  assign m_axis_tvalid = tx_busy_q & ~rst;
  assign m_axis_tlast  = tx_last_q & ~rst;
  assign m_axis_tkeep  = tx_keep_q & {AXIS_KEEP_WIDTH{~rst}};
  assign m_axis_tdata  = tx_data_q & {AXIS_DATA_WIDTH{~rst}};

endmodule

// File: tb/tb_gpc_axi_register.sv
// Self-checking bench for gpc_axi_register: register access, TX/RX beats,
// strobes, error responses and mid-operation reset.
module tb_gpc_axi_register;

`ifdef GPC_AXI_REGISTER_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  s_axil_araddr = '0, s_axil_awaddr = '0, s_axil_wdata = '0;
  logic [2:0]   s_axil_arprot = '0, s_axil_awprot = '0;
  logic         s_axil_arvalid = 1'b0, s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0;
  logic         s_axil_rready = 1'b1, s_axil_bready = 1'b1;
  logic [7:0]   s_axil_wstrb = '0;
  logic         s_axil_arready, s_axil_rvalid, s_axil_awready, s_axil_wready, s_axil_bvalid;
  logic [63:0]  s_axil_rdata;
  logic [1:0]   s_axil_rresp, s_axil_bresp;
  logic [511:0] s_axis_tdata = '0, m_axis_tdata;
  logic [63:0]  s_axis_tkeep = '0, m_axis_tkeep;
  logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
  logic         m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [65:0] exp_q[$];
  logic [63:0] tx_model[8];

  gpc_axi_register dut (
    .clk(clk), .rst(rst),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready), .s_axil_rresp(s_axil_rresp),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic axil_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, output logic [1:0] resp);
    int n;
    n = 0;
    @(negedge clk);
    s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    while (!(s_axil_awready && s_axil_wready) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL write_accept addr=%h: no awready/wready within 20 cycles", addr);
    end
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n = 0;
    while (!s_axil_bvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL write_bvalid addr=%h: no bvalid within 20 cycles", addr);
      resp = 2'bxx;
    end else resp = s_axil_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axil_read(input logic [63:0] addr, output logic [63:0] data,
                           output logic [1:0] resp);
    int n;
    n = 0;
    @(negedge clk);
    s_axil_araddr = addr; s_axil_arvalid = 1'b1;
    while (!s_axil_arready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL read_accept addr=%h: no arready within 20 cycles", addr);
    end
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    n = 0;
    while (!s_axil_rvalid && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL read_rvalid addr=%h: no rvalid within 20 cycles", addr);
      data = 'x; resp = 2'bxx;
    end else begin
      data = s_axil_rdata; resp = s_axil_rresp;
    end
    @(posedge clk); #1;
  endtask

  // Tests
  task automatic test_reset();
    logic [63:0] addrs[9];
    logic [63:0] d;
    logic [1:0]  r;
    logic [65:0] e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
         s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 8'h00 || m_axis_tdata !== '0 ||
        m_axis_tkeep !== '0 || s_axil_rdata !== '0)
      $display("FAIL reset_outputs: got tvalid=%b tready=%b bvalid=%b rvalid=%b, required all 0",
               m_axis_tvalid, s_axis_tready, s_axil_bvalid, s_axil_rvalid);
    else pass_cnt++;
    rst = 1'b0;
    addrs = '{64'h00, 64'h08, 64'h10, 64'h18, 64'h20, 64'h28, 64'h30, 64'h40, 64'h80};
    foreach (addrs[i]) exp_q.push_back({2'b00, 64'h0});
    foreach (addrs[i]) begin
      axil_read(addrs[i], d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL reset_reg addr=%h: got resp=%b data=%h, required resp=%b data=%h",
                 addrs[i], r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_tx_data_rw();
    logic [63:0] d;
    logic [1:0]  r;
    logic [65:0] e;
    axil_write(64'h40, 64'hDEADBEEF_00000001, 8'hFF, r);
    tx_model[0] = 64'hDEADBEEF_00000001;
    total_cnt++;
    if (r !== 2'b00) $display("FAIL tx_data_bresp: got %b, required 00", r);
    else pass_cnt++;
    tx_model[7] = {$urandom(), $urandom()};
    axil_write(64'h78, tx_model[7], 8'hFF, r);
    exp_q.push_back({2'b00, tx_model[0]});
    exp_q.push_back({2'b00, tx_model[7]});
    for (int i = 0; i < 2; i++) begin
      axil_read(i == 0 ? 64'h40 : 64'h78, d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL tx_data_readback[%0d]: got resp=%b data=%h, required resp=%b data=%h",
                 i, r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_strobe_and_err();
    logic [63:0] addrs[4];
    logic [63:0] d;
    logic [1:0]  r;
    logic [65:0] e;
    axil_write(64'h10, 64'h11223344_55667788, 8'hFF, r);
    axil_write(64'h10, 64'hFFFFFFFF_FFFFFFFF, 8'h01, r);
    axil_write(64'h20, 64'h0000_FFFF, 8'hFF, r);
    axil_write(64'h100, 64'h1, 8'hFF, r);
    total_cnt++;
    if (r !== 2'b10) $display("FAIL slverr_bresp: got %b, required 10", r);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (s_axis_tready !== 1'b0)
      $display("FAIL slverr_no_alias: tready got %b, required 0", s_axis_tready);
    else pass_cnt++;
    addrs = '{64'h10, 64'h20, 64'h100, 64'hC0};
    exp_q.push_back({2'b00, 64'h11223344_556677FF});
    exp_q.push_back({2'b00, 64'h0});
    exp_q.push_back({2'b10, 64'h0});
    exp_q.push_back({2'b10, 64'h0});
    foreach (addrs[i]) begin
      axil_read(addrs[i], d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL strobe_err addr=%h: got resp=%b data=%h, required resp=%b data=%h",
                 addrs[i], r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_tx();
    logic [511:0] exp_tdata;
    logic [63:0]  addrs[4];
    logic [63:0]  d;
    logic [1:0]   r;
    logic [65:0]  e;
    int beats;
    tx_model[1] = 64'hCAFEF00D_12345678;
    axil_write(64'h48, tx_model[1], 8'hFF, r);
    axil_write(64'h10, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, r);
    axil_write(64'h18, 64'h1, 8'hFF, r);
    foreach (tx_model[i]) exp_tdata[64*i +: 64] = tx_model[i];
    m_axis_tready = 1'b0;
    axil_write(64'h00, 64'h2, 8'hFF, r);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total_cnt++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_tdata ||
          m_axis_tkeep !== '1 || m_axis_tlast !== 1'b1)
        $display("FAIL tx_stall[%0d]: got tvalid=%b tkeep=%h tlast=%b w0=%h, required 1 %h 1 %h",
                 c, m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata[63:0],
                 64'hFFFFFFFF_FFFFFFFF, tx_model[0]);
      else pass_cnt++;
    end
    axil_write(64'h10, 64'h0, 8'hFF, r);
    axil_write(64'h00, 64'h2, 8'hFF, r);
    exp_q.push_back({2'b00, 64'h1});
    axil_read(64'h08, d, r);
    e = exp_q.pop_front();
    total_cnt++;
    if ({r, d} !== e || m_axis_tkeep !== '1)
      $display("FAIL tx_busy_status: got status=%h tkeep=%h, required status=%h tkeep=all-ones",
               d, m_axis_tkeep, e[63:0]);
    else pass_cnt++;
    beats = 0;
    @(negedge clk);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (m_axis_tvalid && m_axis_tready) beats++;
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
    total_cnt++;
    if (beats !== 1 || m_axis_tvalid !== 1'b0)
      $display("FAIL tx_beats: got beats=%0d tvalid=%b, required beats=1 tvalid=0",
               beats, m_axis_tvalid);
    else pass_cnt++;
    addrs = '{64'h08, 64'h38, 64'h10, 64'h48};
    exp_q.push_back({2'b00, 64'h0});
    exp_q.push_back({2'b00, CNT_ON ? 64'h1 : 64'h0});
    exp_q.push_back({2'b00, 64'hFFFFFFFF_FFFFFFFF});
    exp_q.push_back({2'b00, tx_model[1]});
    foreach (addrs[i]) begin
      axil_read(addrs[i], d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL tx_after addr=%h: got resp=%b data=%h, required resp=%b data=%h",
                 addrs[i], r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_rx();
    logic [511:0] beat1, beat2;
    logic [63:0]  addrs[7];
    logic [63:0]  d;
    logic [1:0]   r;
    logic [65:0]  e;
    for (int i = 0; i < 16; i++) begin
      beat1[32*i +: 32] = $urandom();
      beat2[32*i +: 32] = $urandom();
    end
    axil_write(64'h00, 64'h1, 8'hFF, r);
    @(negedge clk);
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL rx_ready_on: got %b, required 1", s_axis_tready);
    else pass_cnt++;
    s_axis_tdata = beat1; s_axis_tkeep = 64'hFF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tdata = beat2; s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (s_axis_tready !== 1'b0) $display("FAIL rx_ready_full: got %b, required 0", s_axis_tready);
    else pass_cnt++;
    addrs = '{64'h20, 64'h28, 64'h08, 64'h80, 64'hB8, 64'h30, 64'h88};
    exp_q.push_back({2'b00, 64'hFF});
    exp_q.push_back({2'b00, 64'h1});
    exp_q.push_back({2'b00, 64'h2});
    exp_q.push_back({2'b00, beat1[63:0]});
    exp_q.push_back({2'b00, beat1[511:448]});
    exp_q.push_back({2'b00, CNT_ON ? 64'h1 : 64'h0});
    exp_q.push_back({2'b00, beat1[127:64]});
    foreach (addrs[i]) begin
      axil_read(addrs[i], d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL rx_regs addr=%h: got resp=%b data=%h, required resp=%b data=%h",
                 addrs[i], r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
    axil_write(64'h08, 64'h2, 8'hFF, r);
    @(negedge clk);
    total_cnt++;
    if (s_axis_tready !== 1'b1) $display("FAIL rx_w1c_ready: got %b, required 1", s_axis_tready);
    else pass_cnt++;
    s_axis_tdata = beat2; s_axis_tkeep = 64'h0F0F; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    @(posedge clk); #1 s_axis_tvalid = 1'b0;
    axil_write(64'h00, 64'h5, 8'hFF, r);
    addrs = '{64'h98, 64'h20, 64'h28, 64'h30, 64'h38, 64'h00, 64'h08};
    exp_q.push_back({2'b00, beat2[255:192]});
    exp_q.push_back({2'b00, 64'h0F0F});
    exp_q.push_back({2'b00, 64'h0});
    exp_q.push_back({2'b00, 64'h0});
    exp_q.push_back({2'b00, 64'h0});
    exp_q.push_back({2'b00, 64'h1});
    exp_q.push_back({2'b00, 64'h2});
    foreach (addrs[i]) begin
      axil_read(addrs[i], d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL rx_second addr=%h: got resp=%b data=%h, required resp=%b data=%h",
                 addrs[i], r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] addrs[8];
    logic [63:0] d;
    logic [1:0]  r;
    logic [65:0] e;
    m_axis_tready = 1'b0;
    axil_write(64'h00, 64'h2, 8'hFF, r);
    @(negedge clk);
    total_cnt++;
    if (m_axis_tvalid !== 1'b1) $display("FAIL mid_tx_start: tvalid got %b, required 1", m_axis_tvalid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0)
      $display("FAIL mid_rst_outputs: got tvalid=%b tlast=%b, required 0 0", m_axis_tvalid, m_axis_tlast);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0)
      $display("FAIL mid_after_rst: got tvalid=%b tready=%b, required 0 0", m_axis_tvalid, s_axis_tready);
    else pass_cnt++;
    addrs = '{64'h00, 64'h08, 64'h10, 64'h18, 64'h40, 64'h20, 64'h80, 64'h38};
    foreach (addrs[i]) exp_q.push_back({2'b00, 64'h0});
    foreach (addrs[i]) begin
      axil_read(addrs[i], d, r);
      e = exp_q.pop_front();
      total_cnt++;
      if ({r, d} !== e)
        $display("FAIL mid_rst_reg addr=%h: got resp=%b data=%h, required resp=%b data=%h",
                 addrs[i], r, d, e[65:64], e[63:0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    foreach (tx_model[i]) tx_model[i] = 64'h0;
    test_reset();
    test_tx_data_rw();
    test_strobe_and_err();
    test_tx();
    test_rx();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
